dma_ctrl: RTL and testbench



---
 rtl/dma_pkg.sv | 26 ++
 rtl/dma_ctrl_if.sv | 33 +++
 rtl/dma_cfg_regs.sv | 62 ++++++
 rtl/dma_ctrl.sv | 132 +++++++++++++
 tb/tb_dma_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the HOLD/HLDA block-transfer engine:
// state encoding, config-select codes and CTRL bit positions.
package dma_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_SET_SRC = 3'd2,
        S_READ    = 3'd3,
        S_SET_DST = 3'd4,
        S_WRITE   = 3'd5,
        S_RELEASE = 3'd6
    } state_t;

    localparam logic [1:0] SEL_SRC   = 2'd0;
    localparam logic [1:0] SEL_DST   = 2'd1;
    localparam logic [1:0] SEL_COUNT = 2'd2;
    localparam logic [1:0] SEL_CTRL  = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_FILL    = 1;
    localparam int CTRL_IRQ_CLR = 2;

endpackage

// File: rtl/dma_ctrl_if.sv
// Config, HOLD/HLDA and shared memory-port signals of the DMA engine.
// master = the DMA side, slave = CPU/controller/memory side.
interface dma_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cfg_we;
    logic [1:0]        cfg_sel;
    logic [ADDR_W-1:0] cfg_data;
    logic              hlda;
    logic [DATA_W-1:0] mem_rdata;
    logic              hold;
    logic              busy;
    logic              done;
    logic              irq;
    logic              bus_own;
    logic              mem_mar_write_en;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        input  cfg_we, cfg_sel, cfg_data, hlda, mem_rdata,
        output hold, busy, done, irq, bus_own,
        output mem_mar_write_en, mem_write_en, mem_addr, mem_wdata
    );

    modport slave (
        output cfg_we, cfg_sel, cfg_data, hlda, mem_rdata,
        input  hold, busy, done, irq, bus_own,
        input  mem_mar_write_en, mem_write_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dma_cfg_regs.sv
// SRC/DST/COUNT/mode/irq registers: config writes land only while idle,
// the FSM advances the pointers once per completed byte.
module dma_cfg_regs
    import dma_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [ADDR_W-1:0] cfg_data,
    input  logic              busy,
    input  logic              step,
    input  logic              irq_set,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [CNT_W-1:0]  count,
    output logic              fill,
    output logic              start,
    output logic              irq
);
    logic ctrl_wr;
    logic wr_idle;

    assign ctrl_wr = cfg_we && (cfg_sel == SEL_CTRL);
    assign wr_idle = cfg_we && !busy;
    // start is a strobe, never stored: it only exists in the write cycle
    assign start   = ctrl_wr && !busy && cfg_data[CTRL_START];

    always_ff @(posedge clk) begin
        if (rst) begin
            src   <= '0;
            dst   <= '0;
            count <= '0;
            fill  <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (wr_idle) begin
                case (cfg_sel)
                    SEL_SRC:   src   <= cfg_data;
                    SEL_DST:   dst   <= cfg_data;
                    SEL_COUNT: count <= cfg_data[CNT_W-1:0];
                    SEL_CTRL:  fill  <= cfg_data[CTRL_FILL];
                    default:   ;
                endcase
            end
            if (step) begin
                dst   <= dst + ADDR_W'(1);
                count <= count - CNT_W'(1);
                if (!fill)
                    src <= src + ADDR_W'(1);
            end
            // Completion beats a simultaneous clear so an interrupt is never lost
            if (irq_set)
                irq <= 1'b1;
            else if (ctrl_wr && cfg_data[CTRL_IRQ_CLR])
                irq <= 1'b0;
        end
    end
endmodule

// File: rtl/dma_ctrl.sv
// Memory-to-memory copy / constant-fill DMA engine sharing the CPU memory
// port via HOLD/HLDA; all bus activity is qualified by the live hlda.
module dma_ctrl
    import dma_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    dma_ctrl_if.master bus
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src, dst;
    logic [CNT_W-1:0]  count;
    logic              fill, start, irq;
    logic              busy, step, irq_set;
    logic [DATA_W-1:0] rdata_lat;

    logic              hold_req, own, mar_we, mem_we, done_p;
    logic [ADDR_W-1:0] addr_drv;
    logic [DATA_W-1:0] wdata_drv;

    assign busy    = (state != S_IDLE);
    assign step    = (state == S_WRITE) && bus.hlda;
    assign irq_set = (state == S_RELEASE);

    dma_cfg_regs #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_cfg (
        .clk     (clk),
        .rst     (rst),
        .cfg_we  (bus.cfg_we),
        .cfg_sel (bus.cfg_sel),
        .cfg_data(bus.cfg_data),
        .busy    (busy),
        .step    (step),
        .irq_set (irq_set),
        .src     (src),
        .dst     (dst),
        .count   (count),
        .fill    (fill),
        .start   (start),
        .irq     (irq)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Memory output is valid the cycle after the MAR load, i.e. during READ
    always_ff @(posedge clk) begin
        if (rst)
            rdata_lat <= '0;
        else if (state == S_READ && bus.hlda)
            rdata_lat <= bus.mem_rdata;
    end

    always_comb begin
        state_nxt = state;
        hold_req  = 1'b0;
        own       = 1'b0;
        mar_we    = 1'b0;
        mem_we    = 1'b0;
        done_p    = 1'b0;
        addr_drv  = '0;
        wdata_drv = '0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = (count == '0) ? S_RELEASE : S_REQ;
            end
            S_REQ: begin
                hold_req = 1'b1;
                if (bus.hlda)
                    state_nxt = fill ? S_SET_DST : S_SET_SRC;
            end
            S_SET_SRC: begin
                hold_req = 1'b1;
                if (bus.hlda) begin
                    own       = 1'b1;
                    mar_we    = 1'b1;
                    addr_drv  = src;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                hold_req = 1'b1;
                if (bus.hlda)
                    state_nxt = S_SET_DST;
            end
            S_SET_DST: begin
                hold_req = 1'b1;
                if (bus.hlda) begin
                    own       = 1'b1;
                    mar_we    = 1'b1;
                    addr_drv  = dst;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                hold_req = 1'b1;
                if (bus.hlda) begin
                    own       = 1'b1;
                    mem_we    = 1'b1;
                    wdata_drv = fill ? src[DATA_W-1:0] : rdata_lat;
                    if (count == CNT_W'(1))
                        state_nxt = S_RELEASE;
                    else
                        state_nxt = fill ? S_SET_DST : S_SET_SRC;
                end
            end
            S_RELEASE: begin
                done_p    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.hold             = hold_req;
    assign bus.busy             = busy;
    assign bus.done             = done_p;
    assign bus.irq              = irq;
    assign bus.bus_own          = own;
    assign bus.mem_mar_write_en = mar_we;
    assign bus.mem_write_en     = mem_we;
    assign bus.mem_addr         = addr_drv;
    assign bus.mem_wdata        = wdata_drv;
endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: 64K byte memory behind a MAR, hlda = hold delayed two
// cycles, table of transfers plus HLDA-drop and reset/ignore sequences.
`timescale 1ns/1ps
module tb_dma_ctrl;
    import dma_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  cnt;
        logic        fill;
        logic [7:0]  pat;
        int          exp_cyc;
        int          exp_own;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    dma_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0]  mem [0:65535];
    logic [15:0] mar        = '0;
    logic        hd0        = 1'b0;
    logic        hd1        = 1'b0;
    logic        hlda_block = 1'b0;
    logic        pre_we     = 1'b0;
    logic [15:0] pre_addr   = '0;
    logic [7:0]  pre_data   = '0;
    logic [15:0] watch_addr = 16'hDEAD;

    int obs_n = 0, own_cnt = 0, hold_cnt = 0, bad_cnt = 0, watch_hits = 0;
    logic [15:0] obs_addr [0:1023];
    logic [7:0]  obs_data [0:1023];

    int n_checks = 0;
    int n_fail   = 0;
    wr_t  exp_q[$];
    vec_t vecs[6];

    assign bus.hlda      = hd1 & ~hlda_block;
    assign bus.mem_rdata = mem[mar];

    // Memory, MAR, grant delay line and bus monitor counters
    always @(posedge clk) begin
        hd0 <= bus.hold;
        hd1 <= hd0;
        if (bus.mem_mar_write_en) begin
            mar <= bus.mem_addr;
            if (bus.mem_addr == watch_addr)
                watch_hits <= watch_hits + 1;
        end
        if (bus.mem_write_en) begin
            mem[mar]        <= bus.mem_wdata;
            obs_addr[obs_n] <= mar;
            obs_data[obs_n] <= bus.mem_wdata;
            obs_n           <= obs_n + 1;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end
        if (bus.bus_own)
            own_cnt <= own_cnt + 1;
        if (bus.hold)
            hold_cnt <= hold_cnt + 1;
        if (((bus.mem_write_en || bus.mem_mar_write_en || bus.bus_own) && !bus.hlda) ||
            (bus.mem_write_en && bus.mem_mar_write_en))
            bad_cnt <= bad_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [15:0] data);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = sel;
        bus.cfg_data = data;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic wait_done(inout int n);
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_writes(input string tag, input int obs0, input int nexp);
        check({tag, "_nwrites"}, obs_n - obs0, nexp);
        for (int i = obs0; i < obs_n; i++) begin
            if (exp_q.size() == 0) begin
                check({tag, "_extra_write"}, obs_addr[i], 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check({tag, "_waddr"}, obs_addr[i], e.a);
                check({tag, "_wdata"}, obs_data[i], e.d);
            end
        end
        exp_q.delete();
    endtask

    task automatic push_copy(input logic [15:0] src, input logic [15:0] dst,
                             input int cnt, input logic fill, input logic [7:0] pat);
        logic [7:0] d;
        d = pat;
        for (int i = 0; i < cnt; i++) begin
            wr_t e;
            e.a = dst + 16'(i);
            e.d = fill ? src[7:0] : d;
            exp_q.push_back(e);
            if (!fill)
                preload(src + 16'(i), d);
            d = d + 8'h11;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n, own0, hold0, bad0, obs0, w0;
        string tag;
        tag = $sformatf("vec%0d", idx);
        push_copy(v.src, v.dst, int'(v.cnt), v.fill, v.pat);
        cfg_write(SEL_SRC, v.src);
        cfg_write(SEL_DST, v.dst);
        cfg_write(SEL_COUNT, {8'h00, v.cnt});
        watch_addr = v.src;
        own0  = own_cnt;
        hold0 = hold_cnt;
        bad0  = bad_cnt;
        obs0  = obs_n;
        w0    = watch_hits;
        cfg_write(SEL_CTRL, {14'd0, v.fill, 1'b1});
        n = 1;
        wait_done(n);
        check({tag, "_cycles"}, n, v.exp_cyc);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 1'b0);
        check({tag, "_irq"}, bus.irq, 1'b1);
        check({tag, "_hold_idle"}, {bus.hold, bus.busy}, 2'b00);
        check({tag, "_own_cycles"}, own_cnt - own0, v.exp_own);
        check({tag, "_strobe_rules"}, bad_cnt - bad0, 0);
        if (v.cnt == 0)
            check({tag, "_no_hold"}, hold_cnt - hold0, 0);
        if (v.fill)
            check({tag, "_no_src_mar"}, watch_hits - w0, 0);
        check_writes(tag, obs0, int'(v.cnt));
        cfg_write(SEL_CTRL, 16'h0004);
        check({tag, "_irq_clr"}, bus.irq, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, own0, bad0, obs0;
        logic quiet;

        bus.cfg_we   = 1'b0;
        bus.cfg_sel  = 2'd0;
        bus.cfg_data = '0;

        vecs[0] = '{16'h0010, 16'h0080, 8'd3, 1'b0, 8'hAA, 16, 9};
        vecs[1] = '{16'h0055, 16'h0200, 8'd4, 1'b1, 8'h00, 12, 8};
        vecs[2] = '{16'h0077, 16'hFFFE, 8'd3, 1'b1, 8'h00, 10, 6};
        vecs[3] = '{16'h0000, 16'h0000, 8'd0, 1'b0, 8'h00, 1, 0};
        vecs[4] = '{16'hFFFF, 16'h1000, 8'd2, 1'b0, 8'h31, 12, 6};
        vecs[5] = '{16'h0123, 16'h0300, 8'd1, 1'b1, 8'h00, 6, 2};

        repeat (3) @(negedge clk);
        check("reset_ctl", {bus.hold, bus.busy, bus.done, bus.irq, bus.bus_own,
                            bus.mem_mar_write_en, bus.mem_write_en}, 7'd0);
        check("reset_bus", {bus.mem_addr, bus.mem_wdata}, 24'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_vec(i, vecs[i]);

        // Grant withdrawn for three cycles while in READ of a 2-byte copy
        push_copy(16'h0500, 16'h0600, 2, 1'b0, 8'h5A);
        cfg_write(SEL_SRC, 16'h0500);
        cfg_write(SEL_DST, 16'h0600);
        cfg_write(SEL_COUNT, 16'h0002);
        own0 = own_cnt;
        bad0 = bad_cnt;
        obs0 = obs_n;
        cfg_write(SEL_CTRL, 16'h0001);
        n = 1;
        while (!bus.mem_mar_write_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drop_setsrc_cycle", n, 4);
        @(negedge clk);
        n++;
        hlda_block = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            quiet = !(bus.bus_own || bus.mem_mar_write_en || bus.mem_write_en);
            check("drop_quiet", quiet, 1'b1);
            check("drop_hold", bus.hold, 1'b1);
            @(negedge clk);
            n++;
        end
        hlda_block = 1'b0;
        wait_done(n);
        check("drop_cycles", n, 15);
        @(negedge clk);
        check("drop_own_cycles", own_cnt - own0, 6);
        check("drop_strobe_rules", bad_cnt - bad0, 0);
        check_writes("drop", obs0, 2);
        check("drop_mem0", mem[16'h0600], 8'h5A);
        check("drop_mem1", mem[16'h0601], 8'h6B);
        check("drop_irq", bus.irq, 1'b1);

        // Busy-time DST write is ignored; reset lands in the first WRITE
        cfg_write(SEL_SRC, 16'h0700);
        push_copy(16'h0700, 16'h0800, 3, 1'b0, 8'h10);
        cfg_write(SEL_DST, 16'h0800);
        cfg_write(SEL_COUNT, 16'h0003);
        obs0 = obs_n;
        cfg_write(SEL_CTRL, 16'h0001);
        cfg_write(SEL_DST, 16'h0900);
        n = 0;
        while (!bus.mem_write_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_write", bus.mem_write_en, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_ctl", {bus.hold, bus.busy, bus.done, bus.irq, bus.bus_own,
                          bus.mem_mar_write_en, bus.mem_write_en}, 7'd0);
        check_writes("rst", obs0, 1);
        check("rst_mem_kept", mem[16'h0800], 8'h10);
        repeat (4) @(negedge clk);
        check("rst_stays_idle", {bus.hold, bus.busy}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
